// File: rtl/matrix_stream_loader_if.sv
// Stream-in / matrix-out bundle between the element source, the loader and the C consumer.
// Pure wiring, no latency of its own.
// Backpressure: in_ready gates the element stream, c_ready releases a held result.
interface matrix_stream_loader_if #(
    parameter int N     = 4,
    parameter int WIDTH = 16
);
    logic             abort;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] A_out [N][N];
    logic [WIDTH-1:0] B_out [N][N];
    logic             mat_loaded;
    logic             c_valid;
    logic             c_ready;

    // Source / consumer side: drives the stream and the result acknowledge.
    modport master (
        output abort,
        output in_valid,
        output in_data,
        output c_ready,
        input  in_ready,
        input  A_out,
        input  B_out,
        input  mat_loaded,
        input  c_valid
    );

    // Loader side: accepts the stream and presents the assembled matrices.
    modport slave (
        input  abort,
        input  in_valid,
        input  in_data,
        input  c_ready,
        output in_ready,
        output A_out,
        output B_out,
        output mat_loaded,
        output c_valid
    );
endinterface

// File: rtl/matrix_stream_loader.sv
// Assembles a row-major A-then-B element stream into parallel N x N arrays for the multiplier.
// Latency: c_valid rises LATENCY edges after the edge accepting the last B element.
// Backpressure: in_ready drops from full load until c_ready is seen in HOLD; abort restarts.
module matrix_stream_loader #(
    parameter int N           = 4,
    parameter int WIDTH       = 16,
    parameter int PIPE_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    matrix_stream_loader_if.slave bus
);
    localparam int LATENCY = PIPE_STAGES + N + 1;
    localparam int RW      = (N > 1) ? $clog2(N) : 1;
    localparam int CW      = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        WAIT,
        HOLD
    } state_t;

    state_t        state;
    // row/col together are the element index k: row = k / N, col = k % N.
    logic [RW-1:0] row;
    logic [RW-1:0] col;
    logic [RW-1:0] next_row;
    logic [RW-1:0] next_col;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          last_beat;

    assign accept    = bus.in_valid && bus.in_ready;
    assign last_beat = (row == RW'(N - 1)) && (col == RW'(N - 1));

    // Row-major index advance; wraps to [0][0] after the last element of a matrix.
    always_comb begin
        next_row = row;
        next_col = col;
        if (last_beat) begin
            next_row = '0;
            next_col = '0;
        end else if (col == RW'(N - 1)) begin
            next_row = row + RW'(1);
            next_col = '0;
        end else begin
            next_col = col + RW'(1);
        end
    end

    // Load/wait/hold sequencer; all handshake outputs and the arrays are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= LOAD_A;
            row            <= '0;
            col            <= '0;
            cnt            <= '0;
            bus.in_ready   <= 1'b0;
            bus.mat_loaded <= 1'b0;
            bus.c_valid    <= 1'b0;
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    bus.A_out[i][j] <= '0;
                    bus.B_out[i][j] <= '0;
                end
            end
        end else if (bus.abort) begin
            // Abort wins over any beat or acknowledge this cycle; arrays are left as they are.
            state          <= LOAD_A;
            row            <= '0;
            col            <= '0;
            cnt            <= '0;
            bus.in_ready   <= 1'b1;
            bus.mat_loaded <= 1'b0;
            bus.c_valid    <= 1'b0;
        end else begin
            case (state)
                LOAD_A: begin
                    bus.in_ready <= 1'b1;
                    if (accept) begin
                        bus.A_out[row][col] <= bus.in_data;
                        row                 <= next_row;
                        col                 <= next_col;
                        if (last_beat) begin
                            state <= LOAD_B;
                        end
                    end
                end
                LOAD_B: begin
                    if (accept) begin
                        bus.B_out[row][col] <= bus.in_data;
                        row                 <= next_row;
                        col                 <= next_col;
                        if (last_beat) begin
                            state          <= WAIT;
                            bus.in_ready   <= 1'b0;
                            bus.mat_loaded <= 1'b1;
                            cnt            <= CW'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    // The final decrement edge plus the edge into HOLD give LATENCY edges in total.
                    if (cnt == '0) begin
                        state       <= HOLD;
                        bus.c_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                HOLD: begin
                    if (bus.c_ready) begin
                        state          <= LOAD_A;
                        bus.c_valid    <= 1'b0;
                        bus.mat_loaded <= 1'b0;
                        bus.in_ready   <= 1'b1;
                    end
                end
                default: begin
                    state <= LOAD_A;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_stream_loader.sv
// Self-checking bench for matrix_stream_loader against a beat-index reference model.
// Latency: expects c_valid LATENCY edges after the last accepted B element.
// Backpressure: exercises idle/toggled/random in_valid, held and tied c_ready, abort and async reset.
module tb_matrix_stream_loader;
    localparam int N           = 4;
    localparam int WIDTH       = 16;
    localparam int PIPE_STAGES = 2;
    localparam int LATENCY     = PIPE_STAGES + N + 1;
    localparam int NN          = N * N;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    matrix_stream_loader_if #(.N(N), .WIDTH(WIDTH)) bus ();

    matrix_stream_loader #(
        .N          (N),
        .WIDTH      (WIDTH),
        .PIPE_STAGES(PIPE_STAGES)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: expected arrays and the position in the 2*N*N beat sequence.
    logic [WIDTH-1:0] exp_a [N][N];
    logic [WIDTH-1:0] exp_b [N][N];
    int               mdl_k;
    logic [WIDTH-1:0] stim_q [$];

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                exp_a[i][j] = '0;
                exp_b[i][j] = '0;
            end
        end
        mdl_k = 0;
    endfunction

    function automatic void model_accept(input logic [WIDTH-1:0] d);
        if (mdl_k < NN) exp_a[mdl_k / N][mdl_k % N] = d;
        else            exp_b[(mdl_k - NN) / N][(mdl_k - NN) % N] = d;
        mdl_k = (mdl_k + 1) % (2 * NN);
    endfunction

    function automatic int arrays_diff();
        int d = 0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (bus.A_out[i][j] !== exp_a[i][j]) d++;
                if (bus.B_out[i][j] !== exp_b[i][j]) d++;
            end
        end
        return d;
    endfunction

    // Elements where (A_out x B_out) differs from the expected A matrix.
    function automatic int product_vs_a();
        int d = 0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                int acc = 0;
                for (int k = 0; k < N; k++) acc += int'(bus.A_out[i][k]) * int'(bus.B_out[k][j]);
                if (WIDTH'(acc) !== exp_a[i][j]) d++;
            end
        end
        return d;
    endfunction

    function automatic void fill_basic();
        stim_q.delete();
        for (int k = 0; k < NN; k++) stim_q.push_back(WIDTH'(k / N + k % N));
        for (int k = 0; k < NN; k++) stim_q.push_back((k / N == k % N) ? WIDTH'(1) : WIDTH'(0));
    endfunction

    function automatic void fill_random(input int beats);
        stim_q.delete();
        for (int k = 0; k < beats; k++) stim_q.push_back(WIDTH'($urandom));
    endfunction

    // Presents stim_q; mode 0 = valid every cycle, 1 = every other cycle, 2 = random.
    // Returns cycles where in_ready was not high, and whether all beats went out in budget.
    task automatic drive_stream(input int mode, output int stalls, output bit done);
        int sent  = 0;
        int t     = 0;
        bit phase = 1'b0;
        bit v;
        stalls = 0;
        while (sent < stim_q.size() && t < 400) begin
            case (mode)
                0:       v = 1'b1;
                1:       begin v = phase; phase = ~phase; end
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus.in_valid = v;
            bus.in_data  = v ? stim_q[sent] : WIDTH'($urandom);
            if (bus.in_ready !== 1'b1) begin
                stalls++;
            end else if (v) begin
                model_accept(stim_q[sent]);
                sent++;
            end
            @(posedge clk);
            #1;
            t++;
        end
        bus.in_valid = 1'b0;
        done = (sent == stim_q.size());
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        model_reset();
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fails++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        n_checks++; if (bus.mat_loaded !== 1'b0) begin n_fails++; $display("FAIL reset_mat_loaded: got %b want 0", bus.mat_loaded); end
        n_checks++; if (bus.c_valid !== 1'b0) begin n_fails++; $display("FAIL reset_c_valid: got %b want 0", bus.c_valid); end
        n_checks++; if (arrays_diff() !== 0) begin n_fails++; $display("FAIL reset_arrays: %0d elements differ, want 0", arrays_diff()); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fails++; $display("FAIL reset_release_pre_edge: in_ready %b want 0", bus.in_ready); end
        @(posedge clk);
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fails++; $display("FAIL reset_release_edge: in_ready %b want 1", bus.in_ready); end
    endtask

    task automatic test_basic_load();
        int  stalls;
        bit  done;
        int  cv_at = 0;
        int  ml_bad = 0;
        fill_basic();
        drive_stream(0, stalls, done);
        n_checks++; if (done !== 1'b1 || stalls !== 0) begin n_fails++; $display("FAIL basic_accept: done %b stalls %0d want 1/0", done, stalls); end
        n_checks++; if (bus.in_ready !== 1'b0 || bus.mat_loaded !== 1'b1 || bus.c_valid !== 1'b0) begin
            n_fails++; $display("FAIL basic_after_last: rdy %b loaded %b cv %b want 0/1/0", bus.in_ready, bus.mat_loaded, bus.c_valid);
        end
        for (int k = 1; k <= LATENCY + 3 && cv_at == 0; k++) begin
            @(posedge clk);
            #1;
            if (bus.mat_loaded !== 1'b1 || bus.in_ready !== 1'b0) ml_bad++;
            if (bus.c_valid === 1'b1) cv_at = k;
        end
        n_checks++; if (cv_at !== LATENCY) begin n_fails++; $display("FAIL basic_latency: c_valid after %0d edges want %0d", cv_at, LATENCY); end
        n_checks++; if (ml_bad !== 0) begin n_fails++; $display("FAIL basic_wait_flags: %0d bad cycles want 0", ml_bad); end
        n_checks++; if (arrays_diff() !== 0) begin n_fails++; $display("FAIL basic_arrays: %0d elements differ want 0", arrays_diff()); end
        n_checks++; if (bus.A_out[3][3] !== WIDTH'(6)) begin n_fails++; $display("FAIL basic_a33: got %0d want 6", bus.A_out[3][3]); end
        n_checks++; if (bus.B_out[2][2] !== WIDTH'(1) || bus.B_out[2][1] !== WIDTH'(0)) begin
            n_fails++; $display("FAIL basic_b22_b21: got %0d/%0d want 1/0", bus.B_out[2][2], bus.B_out[2][1]);
        end
        n_checks++; if (product_vs_a() !== 0) begin n_fails++; $display("FAIL basic_c_eq_a: %0d elements differ want 0", product_vs_a()); end
    endtask

    task automatic test_hold();
        int bad = 0;
        bus.c_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (bus.c_valid !== 1'b1 || bus.in_ready !== 1'b0) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fails++; $display("FAIL hold_stable: %0d bad cycles want 0", bad); end
        bus.c_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.c_ready = 1'b0;
        n_checks++; if (bus.c_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.mat_loaded !== 1'b0) begin
            n_fails++; $display("FAIL hold_release: cv %b rdy %b loaded %b want 0/1/0", bus.c_valid, bus.in_ready, bus.mat_loaded);
        end
        n_checks++; if (arrays_diff() !== 0) begin n_fails++; $display("FAIL hold_arrays_kept: %0d differ want 0", arrays_diff()); end
    endtask

    task automatic test_random_loads();
        for (int it = 0; it < 3; it++) begin
            int stalls;
            bit done;
            int cv_at = 0;
            int bad   = 0;
            int hold  = $urandom_range(0, 5);
            fill_random(2 * NN);
            drive_stream(2, stalls, done);
            n_checks++; if (done !== 1'b1 || stalls !== 0) begin n_fails++; $display("FAIL rand_accept[%0d]: done %b stalls %0d", it, done, stalls); end
            for (int k = 1; k <= LATENCY + 3 && cv_at == 0; k++) begin
                @(posedge clk);
                #1;
                if (bus.c_valid === 1'b1) cv_at = k;
            end
            n_checks++; if (cv_at !== LATENCY) begin n_fails++; $display("FAIL rand_latency[%0d]: %0d edges want %0d", it, cv_at, LATENCY); end
            n_checks++; if (arrays_diff() !== 0) begin n_fails++; $display("FAIL rand_arrays[%0d]: %0d differ want 0", it, arrays_diff()); end
            for (int k = 0; k < hold; k++) begin
                @(posedge clk);
                #1;
                if (bus.c_valid !== 1'b1) bad++;
            end
            bus.c_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.c_ready = 1'b0;
            if (bus.c_valid !== 1'b0 || bus.in_ready !== 1'b1) bad++;
            n_checks++; if (bad !== 0) begin n_fails++; $display("FAIL rand_hold[%0d]: %0d bad cycles want 0", it, bad); end
        end
    endtask

    task automatic test_toggled_valid();
        int stalls;
        bit done;
        int cv_at = 0;
        fill_basic();
        drive_stream(1, stalls, done);
        n_checks++; if (done !== 1'b1 || stalls !== 0) begin n_fails++; $display("FAIL toggle_accept: done %b stalls %0d", done, stalls); end
        for (int k = 1; k <= LATENCY + 3 && cv_at == 0; k++) begin
            @(posedge clk);
            #1;
            if (bus.c_valid === 1'b1) cv_at = k;
        end
        n_checks++; if (cv_at !== LATENCY) begin n_fails++; $display("FAIL toggle_latency: %0d edges want %0d", cv_at, LATENCY); end
        n_checks++; if (arrays_diff() !== 0) begin n_fails++; $display("FAIL toggle_arrays: %0d differ want 0", arrays_diff()); end
        bus.c_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.c_ready = 1'b0;
    endtask

    task automatic test_abort();
        int stalls;
        bit done;
        int cv_seen = 0;
        int cv_at   = 0;
        fill_random(NN + 5);
        drive_stream(0, stalls, done);
        n_checks++; if (done !== 1'b1 || stalls !== 0) begin n_fails++; $display("FAIL abort_preload: done %b stalls %0d", done, stalls); end
        bus.in_valid = 1'b1;
        bus.in_data  = WIDTH'($urandom);
        bus.abort    = 1'b1;
        bus.c_ready  = 1'b1;
        @(posedge clk);
        #1;
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        bus.c_ready  = 1'b0;
        mdl_k        = 0;
        n_checks++; if (bus.in_ready !== 1'b1 || bus.mat_loaded !== 1'b0 || bus.c_valid !== 1'b0) begin
            n_fails++; $display("FAIL abort_state: rdy %b loaded %b cv %b want 1/0/0", bus.in_ready, bus.mat_loaded, bus.c_valid);
        end
        n_checks++; if (arrays_diff() !== 0) begin n_fails++; $display("FAIL abort_discard: %0d differ want 0", arrays_diff()); end
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (bus.c_valid === 1'b1) cv_seen++;
        end
        n_checks++; if (cv_seen !== 0) begin n_fails++; $display("FAIL abort_no_c_valid: %0d cycles high want 0", cv_seen); end
        fill_random(NN);
        drive_stream(0, stalls, done);
        n_checks++; if (arrays_diff() !== 0 || done !== 1'b1) begin
            n_fails++; $display("FAIL abort_reload_a: %0d differ done %b want 0/1", arrays_diff(), done);
        end
        fill_random(NN);
        drive_stream(0, stalls, done);
        for (int k = 1; k <= LATENCY + 3 && cv_at == 0; k++) begin
            @(posedge clk);
            #1;
            if (bus.c_valid === 1'b1) cv_at = k;
        end
        n_checks++; if (cv_at !== LATENCY || arrays_diff() !== 0) begin
            n_fails++; $display("FAIL abort_reload_b: latency %0d diff %0d want %0d/0", cv_at, arrays_diff(), LATENCY);
        end
        bus.c_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.c_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int stalls;
        bit done;
        bus.c_ready = 1'b1;
        for (int ld = 0; ld < 2; ld++) begin
            int cv_at = 0;
            fill_random(2 * NN);
            drive_stream(0, stalls, done);
            n_checks++; if (done !== 1'b1 || stalls !== 0) begin n_fails++; $display("FAIL b2b_accept[%0d]: done %b stalls %0d", ld, done, stalls); end
            for (int k = 1; k <= LATENCY + 3 && cv_at == 0; k++) begin
                @(posedge clk);
                #1;
                if (bus.c_valid === 1'b1) cv_at = k;
            end
            n_checks++; if (cv_at !== LATENCY) begin n_fails++; $display("FAIL b2b_latency[%0d]: %0d edges want %0d", ld, cv_at, LATENCY); end
            n_checks++; if (arrays_diff() !== 0) begin n_fails++; $display("FAIL b2b_arrays[%0d]: %0d differ want 0", ld, arrays_diff()); end
            @(posedge clk);
            #1;
            n_checks++; if (bus.c_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                n_fails++; $display("FAIL b2b_one_cycle[%0d]: cv %b rdy %b want 0/1", ld, bus.c_valid, bus.in_ready);
            end
        end
        bus.c_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        int stalls;
        bit done;
        fill_random(2 * NN);
        drive_stream(0, stalls, done);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++; if (bus.in_ready !== 1'b0 || bus.mat_loaded !== 1'b0 || bus.c_valid !== 1'b0) begin
            n_fails++; $display("FAIL areset_flags: rdy %b loaded %b cv %b want 0/0/0", bus.in_ready, bus.mat_loaded, bus.c_valid);
        end
        n_checks++; if (arrays_diff() !== 0) begin n_fails++; $display("FAIL areset_arrays: %0d differ want 0", arrays_diff()); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (bus.in_ready !== 1'b1 || bus.c_valid !== 1'b0) begin
            n_fails++; $display("FAIL areset_release: rdy %b cv %b want 1/0", bus.in_ready, bus.c_valid);
        end
    endtask

    initial begin
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.c_ready  = 1'b0;
        model_reset();
        test_reset();
        test_basic_load();
        test_hold();
        test_random_loads();
        test_toggled_valid();
        test_abort();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d failures %0d", n_checks, n_fails);
        $fatal(1);
    end
endmodule
